volatility_scheduler: RTL and testbench
=======================================

Name: volatility_scheduler

Overview:
- Front-end controller for `volatility_mem`.
- Accepts mid-price update requests (best ask/bid) from NUM_STOCKS per-stock feed handlers and arbitrates between them round-robin.
- For the granted stock it generates the circular-buffer write address, current fill count and Q32.32 reciprocal, drives one update into `volatility_mem`, then captures the resulting volatility and price.
- The captured result is presented to the quoting engine through a valid/ready handshake.

Parameters:
- FP_WORD_SIZE, 64, width of the volatility and reciprocal words (Q32.32).
- DATA_WIDTH, 32, price width.
- BUFFER_SIZE, 32, samples per stock window; must be a power of two, at least 2.
- NUM_STOCKS, 4, number of requesters; must be a power of two, at least 2.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_req_valid  in  NUM_STOCKS  per-stock update request.
- i_req_ask  in  NUM_STOCKS*DATA_WIDTH  packed best ask; slice s belongs to stock s.
- i_req_bid  in  NUM_STOCKS*DATA_WIDTH  packed best bid; slice s belongs to stock s.
- o_req_ready  out  NUM_STOCKS  one-hot accept.
- o_mem_valid  out  1  update strobe to the memory.
- o_mem_write_address  out  $clog2(NUM_STOCKS*BUFFER_SIZE)  stock*BUFFER_SIZE+ptr.
- o_mem_best_ask, o_mem_best_bid  out  DATA_WIDTH  latched quote.
- o_mem_stock_id  out  $clog2(NUM_STOCKS)  granted stock.
- o_mem_buffer_size  out  DATA_WIDTH  fill count after this write.
- o_mem_buffer_size_reciprocal  out  FP_WORD_SIZE  floor(2^32/fill).
- i_mem_volatility  in  FP_WORD_SIZE  memory result.
- i_mem_curr_price  in  DATA_WIDTH  memory price.
- i_mem_buffer_full  in  1  memory full flag.
- i_mem_data_valid  in  1  memory result valid.
- o_res_valid  out  1  result handshake valid.
- i_res_ready  in  1  result handshake ready.
- o_res_stock_id  out  $clog2(NUM_STOCKS)  stock of the presented result.
- o_res_volatility  out  FP_WORD_SIZE  captured volatility.
- o_res_price  out  DATA_WIDTH  captured price.
- o_res_full  out  1  window full flag for the stock.

Behaviour:
- Clock and reset: single clock i_clk; reset i_reset_n is synchronous, active-low.
- Reset values:
  - FSM goes to IDLE.
  - All write pointers and fill counts are 0.
  - Round-robin pointer is 0.
  - All outputs are 0.
- FSM states: IDLE, ISSUE, SETTLE, RESULT.
- IDLE:
  - If i_req_valid is non-zero, grant the first set bit at or after rr_ptr, wrapping.
  - Assert o_req_ready for that stock this cycle; this is the combinational accept.
  - Latch ask, bid and stock id.
  - Set rr_ptr to grant+1 (mod NUM_STOCKS).
  - Go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE (one cycle):
  - o_mem_valid=1.
  - Address = stock*BUFFER_SIZE + wptr[stock].
  - o_mem_buffer_size = min(fill[stock]+1, BUFFER_SIZE).
  - Reciprocal comes from the LUT for that size.
  - At the clock edge: wptr[stock] advances, wrapping BUFFER_SIZE-1 to 0; fill[stock] increments, saturating at BUFFER_SIZE.
  - Go to SETTLE.
- SETTLE (one cycle):
  - o_mem_valid=0.
  - Stock id and reciprocal are held unchanged, because the memory computes volatility combinationally from them.
  - Capture i_mem_volatility, i_mem_curr_price and i_mem_buffer_full into the result registers.
  - Go to RESULT.
  - If i_mem_data_valid=0 here, still capture and go to RESULT; a sticky sticky_err bit is set (internal, visible to the bench).
- RESULT:
  - o_res_valid=1; result fields are stable until the transfer.
  - Transfer occurs on i_res_ready=1; go to IDLE.
  - A new grant is not possible in the same cycle, so the minimum issue interval is 4 cycles.
- Latency: request accept to o_res_valid is 3 cycles.
- o_req_ready is 0 outside IDLE. Requests stay pending; there is no dropping and no queueing.
- Memory outputs (address, ask, bid, stock id, buffer size, reciprocal) hold their last values outside ISSUE/SETTLE.
- Reciprocal LUT: entry n = floor(2^32/n) for n = 1..BUFFER_SIZE; entry 0 is 0 (unused).
- Boundary conditions:
  - Wrap: 33rd sample for stock 2 (defaults) writes address 64, and the fill count stays 32.
  - Reset asserted mid-transaction: next cycle is IDLE, all outputs are 0, and the pending result is lost.

Optional Feature:
- SKIP_ZERO_QUOTE_EN defined:
  - A request with ask==0 or bid==0 is accepted (ready pulsed) but not issued.
  - FSM stays in IDLE; rr_ptr still advances.
  - Pointers and fill count are unchanged.
- Undefined: such quotes are issued normally.

Decomposition:
- Package volatility_pkg holds:
  - state enum sched_state_t {IDLE, ISSUE, SETTLE, RESULT};
  - RECIP_FRAC_BITS=32;
  - a function recip_q32(n).
- One sub-module, volatility_recip_lut: combinational, parameter BUFFER_SIZE, input size, output FP_WORD_SIZE reciprocal.

Test Plan:
- Single request, stock 1, ask 102, bid 98:
  - o_req_ready[1] pulses.
  - ISSUE has address 32, size 1, reciprocal 0x1_0000_0000.
  - o_res_valid 3 cycles after accept; price 100.
- All four stocks request continuously with i_res_ready=1:
  - grants follow 0,1,2,3,0;
  - one grant every 4 cycles;
  - no grant to a stock not requesting.
- 34 updates to stock 0:
  - addresses run 0..31 then 0, 1;
  - size saturates at 32 with reciprocal 0x0800_0000;
  - o_res_full=1 from the 32nd update.
- Backpressure: hold i_res_ready=0 for 10 cycles:
  - o_res_valid and all result fields are stable;
  - no o_req_ready asserted;
  - exactly one transfer when ready rises.
- Reset asserted during SETTLE: next cycle all outputs are 0, and the next update to that stock writes address stock*32.
- With SKIP_ZERO_QUOTE_EN, stock 3 with ask 0 and bid 50: accepted, no o_mem_valid, and the next valid stock 3 write still uses address 96.

Source files
------------

// File: rtl/volatility_scheduler_pkg.sv
// Shared types and helpers for the volatility scheduler: FSM state encoding
// and the Q32.32 reciprocal used to build the fill-count lookup table.
package volatility_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESULT} sched_state_t;

    localparam int RECIP_FRAC_BITS = 32;

    function automatic logic [63:0] recip_q32(input int unsigned n);
        if (n == 0) begin
            return 64'd0;
        end
        return (64'd1 << RECIP_FRAC_BITS) / 64'(n);
    endfunction

endpackage

// File: rtl/volatility_recip_lut.sv
// Combinational reciprocal table: entry n holds floor(2^32/n) for n = 1..BUFFER_SIZE;
// entry 0 and any out-of-range size return 0.
module volatility_recip_lut
    import volatility_pkg::*;
#(
    parameter int BUFFER_SIZE  = 32,
    parameter int FP_WORD_SIZE = 64,
    parameter int SIZE_W       = $clog2(BUFFER_SIZE + 1)
) (
    input  logic [SIZE_W-1:0]       i_size,
    output logic [FP_WORD_SIZE-1:0] o_reciprocal
);

    logic [FP_WORD_SIZE-1:0] table_w [0:BUFFER_SIZE];

    generate
        for (genvar gi = 0; gi <= BUFFER_SIZE; gi++) begin : g_lut
            assign table_w[gi] = FP_WORD_SIZE'(recip_q32(gi));
        end
    endgenerate

    always_comb begin
        o_reciprocal = '0;
        if (int'(i_size) <= BUFFER_SIZE) begin
            o_reciprocal = table_w[i_size];
        end
    end

endmodule

// File: rtl/volatility_scheduler.sv
// Round-robin front-end for volatility_mem: grants one stock, issues one update,
// captures the result and presents it on a valid/ready port. Optional: SKIP_ZERO_QUOTE_EN.
module volatility_scheduler
    import volatility_pkg::*;
#(
    parameter int FP_WORD_SIZE = 64,
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_SIZE  = 32,
    parameter int NUM_STOCKS   = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset_n,
    input  logic [NUM_STOCKS-1:0]                  i_req_valid,
    input  logic [NUM_STOCKS*DATA_WIDTH-1:0]       i_req_ask,
    input  logic [NUM_STOCKS*DATA_WIDTH-1:0]       i_req_bid,
    output logic [NUM_STOCKS-1:0]                  o_req_ready,
    output logic                                   o_mem_valid,
    output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0] o_mem_write_address,
    output logic [DATA_WIDTH-1:0]                  o_mem_best_ask,
    output logic [DATA_WIDTH-1:0]                  o_mem_best_bid,
    output logic [$clog2(NUM_STOCKS)-1:0]          o_mem_stock_id,
    output logic [DATA_WIDTH-1:0]                  o_mem_buffer_size,
    output logic [FP_WORD_SIZE-1:0]                o_mem_buffer_size_reciprocal,
    input  logic [FP_WORD_SIZE-1:0]                i_mem_volatility,
    input  logic [DATA_WIDTH-1:0]                  i_mem_curr_price,
    input  logic                                   i_mem_buffer_full,
    input  logic                                   i_mem_data_valid,
    output logic                                   o_res_valid,
    input  logic                                   i_res_ready,
    output logic [$clog2(NUM_STOCKS)-1:0]          o_res_stock_id,
    output logic [FP_WORD_SIZE-1:0]                o_res_volatility,
    output logic [DATA_WIDTH-1:0]                  o_res_price,
    output logic                                   o_res_full
);

    localparam int SID_W  = $clog2(NUM_STOCKS);
    localparam int PTR_W  = $clog2(BUFFER_SIZE);
    localparam int ADDR_W = $clog2(NUM_STOCKS * BUFFER_SIZE);
    localparam int FILL_W = $clog2(BUFFER_SIZE + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(BUFFER_SIZE);

    sched_state_t state_q, state_d;
    logic [SID_W-1:0]        rr_q, rr_d;
    logic [PTR_W-1:0]        wptr_q [NUM_STOCKS];
    logic [PTR_W-1:0]        wptr_d [NUM_STOCKS];
    logic [FILL_W-1:0]       fill_q [NUM_STOCKS];
    logic [FILL_W-1:0]       fill_d [NUM_STOCKS];
    logic                    mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_ask_q, mem_ask_d, mem_bid_q, mem_bid_d;
    logic [SID_W-1:0]        mem_sid_q, mem_sid_d;
    logic [FILL_W-1:0]       mem_size_q, mem_size_d;
    logic [FP_WORD_SIZE-1:0] mem_recip_q, mem_recip_d;
    logic                    res_valid_q, res_valid_d;
    logic [SID_W-1:0]        res_sid_q, res_sid_d;
    logic [FP_WORD_SIZE-1:0] res_vol_q, res_vol_d;
    logic [DATA_WIDTH-1:0]   res_price_q, res_price_d;
    logic                    res_full_q, res_full_d;
    logic                    sticky_err_q, sticky_err_d;

    logic [SID_W-1:0]        cand_id [NUM_STOCKS];
    logic                    grant_found;
    logic [SID_W-1:0]        grant_id;
    logic [DATA_WIDTH-1:0]   ask_sel, bid_sel;
    logic [FILL_W-1:0]       fill_sel, size_sel;
    logic [FP_WORD_SIZE-1:0] recip_sel;
    logic                    skip_quote;

    // Candidate k is the k-th stock at or after rr_q; the index wraps naturally.
    generate
        for (genvar gi = 0; gi < NUM_STOCKS; gi++) begin : g_cand
            assign cand_id[gi] = rr_q + SID_W'(gi);
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_id    = rr_q;
        for (int k = NUM_STOCKS - 1; k >= 0; k--) begin
            if (i_req_valid[cand_id[k]]) begin
                grant_found = 1'b1;
                grant_id    = cand_id[k];
            end
        end
    end

    assign ask_sel  = i_req_ask[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign bid_sel  = i_req_bid[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign fill_sel = fill_q[grant_id];
    assign size_sel = (fill_sel == FILL_MAX) ? fill_sel : fill_sel + FILL_W'(1);

`ifdef SKIP_ZERO_QUOTE_EN
    assign skip_quote = (ask_sel == '0) || (bid_sel == '0);
`else
    assign skip_quote = 1'b0;
`endif

    volatility_recip_lut #(
        .BUFFER_SIZE  (BUFFER_SIZE),
        .FP_WORD_SIZE (FP_WORD_SIZE),
        .SIZE_W       (FILL_W)
    ) u_recip_lut (
        .i_size       (size_sel),
        .o_reciprocal (recip_sel)
    );

    // Accept is combinational so the feed handler sees it in the grant cycle.
    assign o_req_ready = (i_reset_n && state_q == IDLE && grant_found)
                         ? (NUM_STOCKS'(1) << grant_id) : '0;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        wptr_d       = wptr_q;
        fill_d       = fill_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_ask_d    = mem_ask_q;
        mem_bid_d    = mem_bid_q;
        mem_sid_d    = mem_sid_q;
        mem_size_d   = mem_size_q;
        mem_recip_d  = mem_recip_q;
        res_valid_d  = res_valid_q;
        res_sid_d    = res_sid_q;
        res_vol_d    = res_vol_q;
        res_price_d  = res_price_q;
        res_full_d   = res_full_q;
        sticky_err_d = sticky_err_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    rr_d = grant_id + SID_W'(1);
                    if (!skip_quote) begin
                        state_d     = ISSUE;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {grant_id, wptr_q[grant_id]};
                        mem_ask_d   = ask_sel;
                        mem_bid_d   = bid_sel;
                        mem_sid_d   = grant_id;
                        mem_size_d  = size_sel;
                        mem_recip_d = recip_sel;
                    end
                end
            end
            ISSUE: begin
                mem_valid_d          = 1'b0;
                wptr_d[mem_sid_q]    = wptr_q[mem_sid_q] + PTR_W'(1);
                fill_d[mem_sid_q]    = (fill_q[mem_sid_q] == FILL_MAX)
                                       ? FILL_MAX : fill_q[mem_sid_q] + FILL_W'(1);
                state_d              = SETTLE;
            end
            SETTLE: begin
                // Memory inputs are still held, so its combinational result is valid now.
                res_valid_d = 1'b1;
                res_sid_d   = mem_sid_q;
                res_vol_d   = i_mem_volatility;
                res_price_d = i_mem_curr_price;
                res_full_d  = i_mem_buffer_full;
                if (!i_mem_data_valid) begin
                    sticky_err_d = 1'b1;
                end
                state_d = RESULT;
            end
            RESULT: begin
                if (i_res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            for (int s = 0; s < NUM_STOCKS; s++) begin
                wptr_q[s] <= '0;
                fill_q[s] <= '0;
            end
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_ask_q    <= '0;
            mem_bid_q    <= '0;
            mem_sid_q    <= '0;
            mem_size_q   <= '0;
            mem_recip_q  <= '0;
            res_valid_q  <= 1'b0;
            res_sid_q    <= '0;
            res_vol_q    <= '0;
            res_price_q  <= '0;
            res_full_q   <= 1'b0;
            sticky_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            wptr_q       <= wptr_d;
            fill_q       <= fill_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_ask_q    <= mem_ask_d;
            mem_bid_q    <= mem_bid_d;
            mem_sid_q    <= mem_sid_d;
            mem_size_q   <= mem_size_d;
            mem_recip_q  <= mem_recip_d;
            res_valid_q  <= res_valid_d;
            res_sid_q    <= res_sid_d;
            res_vol_q    <= res_vol_d;
            res_price_q  <= res_price_d;
            res_full_q   <= res_full_d;
            sticky_err_q <= sticky_err_d;
        end
    end

    assign o_mem_valid                  = mem_valid_q;
    assign o_mem_write_address          = mem_addr_q;
    assign o_mem_best_ask               = mem_ask_q;
    assign o_mem_best_bid               = mem_bid_q;
    assign o_mem_stock_id               = mem_sid_q;
    assign o_mem_buffer_size            = DATA_WIDTH'(mem_size_q);
    assign o_mem_buffer_size_reciprocal = mem_recip_q;
    assign o_res_valid                  = res_valid_q;
    assign o_res_stock_id               = res_sid_q;
    assign o_res_volatility             = res_vol_q;
    assign o_res_price                  = res_price_q;
    assign o_res_full                   = res_full_q;

endmodule

// File: tb/tb_volatility_scheduler.sv
// Directed self-checking bench for volatility_scheduler with a tiny combinational
// stand-in for volatility_mem (price = mid, volatility = reciprocal xor a marker).
module tb_volatility_scheduler;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int BS = 32;
    localparam int FW = 64;
    localparam logic [63:0] VOL_MARK = 64'hA5A5_0000_0000_5A5A;

    logic              clk = 1'b0;
    logic              i_reset_n;
    logic [NS-1:0]     i_req_valid;
    logic [NS*DW-1:0]  i_req_ask, i_req_bid;
    logic [NS-1:0]     o_req_ready;
    logic              o_mem_valid;
    logic [6:0]        o_mem_write_address;
    logic [DW-1:0]     o_mem_best_ask, o_mem_best_bid;
    logic [1:0]        o_mem_stock_id;
    logic [DW-1:0]     o_mem_buffer_size;
    logic [FW-1:0]     o_mem_buffer_size_reciprocal;
    logic [FW-1:0]     i_mem_volatility;
    logic [DW-1:0]     i_mem_curr_price;
    logic              i_mem_buffer_full;
    logic              i_mem_data_valid;
    logic              o_res_valid;
    logic              i_res_ready;
    logic [1:0]        o_res_stock_id;
    logic [FW-1:0]     o_res_volatility;
    logic [DW-1:0]     o_res_price;
    logic              o_res_full;

    logic              mem_dv;
    logic [63:0]       vol_noise;
    logic [269:0]      all_outs;
    int                n_cmp = 0;
    int                n_bad = 0;

    always #5 clk = ~clk;

    assign i_mem_curr_price  = (o_mem_best_ask + o_mem_best_bid) >> 1;
    assign i_mem_volatility  = o_mem_buffer_size_reciprocal ^ VOL_MARK ^ vol_noise;
    assign i_mem_buffer_full = (o_mem_buffer_size == 32'd32);
    assign i_mem_data_valid  = mem_dv;
    assign all_outs = {o_mem_valid, o_mem_write_address, o_mem_best_ask, o_mem_best_bid,
                       o_mem_stock_id, o_mem_buffer_size, o_mem_buffer_size_reciprocal,
                       o_res_valid, o_res_stock_id, o_res_volatility, o_res_price, o_res_full};

    volatility_scheduler dut (
        .i_clk                        (clk),
        .i_reset_n                    (i_reset_n),
        .i_req_valid                  (i_req_valid),
        .i_req_ask                    (i_req_ask),
        .i_req_bid                    (i_req_bid),
        .o_req_ready                  (o_req_ready),
        .o_mem_valid                  (o_mem_valid),
        .o_mem_write_address          (o_mem_write_address),
        .o_mem_best_ask               (o_mem_best_ask),
        .o_mem_best_bid               (o_mem_best_bid),
        .o_mem_stock_id               (o_mem_stock_id),
        .o_mem_buffer_size            (o_mem_buffer_size),
        .o_mem_buffer_size_reciprocal (o_mem_buffer_size_reciprocal),
        .i_mem_volatility             (i_mem_volatility),
        .i_mem_curr_price             (i_mem_curr_price),
        .i_mem_buffer_full            (i_mem_buffer_full),
        .i_mem_data_valid             (i_mem_data_valid),
        .o_res_valid                  (o_res_valid),
        .i_res_ready                  (i_res_ready),
        .o_res_stock_id               (o_res_stock_id),
        .o_res_volatility             (o_res_volatility),
        .o_res_price                  (o_res_price),
        .o_res_full                   (o_res_full)
    );

    function automatic int oh2i(input logic [NS-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        i_reset_n   = 1'b0;
        i_req_valid = '0;
        i_res_ready = 1'b0;
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    // Runs one request from a negedge in IDLE to the result transfer; only captures.
    task automatic run_one(input int s, input logic [31:0] ask, input logic [31:0] bid,
                           output logic [3:0] rdy, output logic mv, output logic [6:0] addr,
                           output logic [31:0] size, output logic [63:0] recip, output int lat,
                           output logic [31:0] price, output logic [63:0] vol,
                           output logic full, output logic [1:0] rsid);
        i_res_ready = 1'b0;
        i_req_valid = '0;
        i_req_valid[s] = 1'b1;
        i_req_ask[s*DW +: DW] = ask;
        i_req_bid[s*DW +: DW] = bid;
        #1 rdy = o_req_ready;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = '0;
        mv = o_mem_valid; addr = o_mem_write_address;
        size = o_mem_buffer_size; recip = o_mem_buffer_size_reciprocal;
        lat = 1;
        while (!o_res_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        price = o_res_price; vol = o_res_volatility; full = o_res_full; rsid = o_res_stock_id;
        $display("txn stock=%0d ready=%b addr=%0d size=%0d recip=%h lat=%0d price=%0d full=%b",
                 s, rdy, addr, size, recip, lat, price, full);
        i_res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_res_ready = 1'b0;
    endtask

    logic [3:0]  t_rdy;
    logic        t_mv, t_full;
    logic [6:0]  t_addr;
    logic [31:0] t_size, t_price;
    logic [63:0] t_recip, t_vol;
    int          t_lat;
    logic [1:0]  t_sid;

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_req_valid = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (o_req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", o_req_ready); end
        n_cmp++; if (all_outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", all_outs); end
        n_cmp++; if (dut.sticky_err_q !== 1'b0) begin n_bad++; $display("FAIL reset_sticky: got %b want 0", dut.sticky_err_q); end
        i_req_valid = '0;
        @(negedge clk);
        i_reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (all_outs !== '0) begin n_bad++; $display("FAIL reset_idle_outputs: got %h want 0", all_outs); end
    endtask

    task automatic test_single();
        run_one(1, 32'd102, 32'd98, t_rdy, t_mv, t_addr, t_size, t_recip, t_lat, t_price, t_vol, t_full, t_sid);
        n_cmp++; if (t_rdy !== 4'b0010) begin n_bad++; $display("FAIL single_ready: got %b want 0010", t_rdy); end
        n_cmp++; if (t_mv !== 1'b1) begin n_bad++; $display("FAIL single_mem_valid: got %b want 1", t_mv); end
        n_cmp++; if (t_addr !== 7'd32) begin n_bad++; $display("FAIL single_addr: got %0d want 32", t_addr); end
        n_cmp++; if (t_size !== 32'd1) begin n_bad++; $display("FAIL single_size: got %0d want 1", t_size); end
        n_cmp++; if (t_recip !== 64'h1_0000_0000) begin n_bad++; $display("FAIL single_recip: got %h want 100000000", t_recip); end
        n_cmp++; if (t_lat !== 3) begin n_bad++; $display("FAIL single_latency: got %0d want 3", t_lat); end
        n_cmp++; if (t_price !== 32'd100) begin n_bad++; $display("FAIL single_price: got %0d want 100", t_price); end
        n_cmp++; if (t_vol !== 64'hA5A5_0001_0000_5A5A) begin n_bad++; $display("FAIL single_vol: got %h want a5a5000100005a5a", t_vol); end
        n_cmp++; if (t_sid !== 2'd1) begin n_bad++; $display("FAIL single_res_stock: got %0d want 1", t_sid); end
        n_cmp++; if (t_full !== 1'b0) begin n_bad++; $display("FAIL single_full: got %b want 0", t_full); end
    endtask

    task automatic test_round_robin();
        int gcyc[$];
        int gid[$];
        int exp_c[5]  = '{0, 4, 8, 12, 16};
        int exp_id[5] = '{0, 1, 2, 3, 0};
        int exp_id2[4] = '{1, 3, 1, 3};
        do_reset();
        i_res_ready = 1'b1;
        i_req_valid = 4'hF;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (o_req_ready != '0) begin gcyc.push_back(c); gid.push_back(oh2i(o_req_ready)); end
            @(negedge clk);
        end
        n_cmp++; if (gcyc.size() != 5) begin n_bad++; $display("FAIL rr_grant_count: got %0d want 5", gcyc.size()); end
        for (int k = 0; k < gcyc.size() && k < 5; k++) begin
            $display("grant cycle=%0d stock=%0d", gcyc[k], gid[k]);
            n_cmp++; if (gcyc[k] != exp_c[k] || gid[k] != exp_id[k]) begin
                n_bad++; $display("FAIL rr_grant%0d: got cycle %0d stock %0d want cycle %0d stock %0d",
                                  k, gcyc[k], gid[k], exp_c[k], exp_id[k]);
            end
        end
        i_req_valid = '0;
        repeat (5) @(negedge clk);
        gcyc.delete(); gid.delete();
        i_req_valid = 4'b1010;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (o_req_ready != '0) begin gcyc.push_back(c); gid.push_back(oh2i(o_req_ready)); end
            @(negedge clk);
        end
        n_cmp++; if (gcyc.size() != 4) begin n_bad++; $display("FAIL rr_sparse_count: got %0d want 4", gcyc.size()); end
        for (int k = 0; k < gid.size() && k < 4; k++) begin
            n_cmp++; if (gid[k] != exp_id2[k] || gcyc[k] != 4 * k) begin
                n_bad++; $display("FAIL rr_sparse%0d: got cycle %0d stock %0d want cycle %0d stock %0d",
                                  k, gcyc[k], gid[k], 4 * k, exp_id2[k]);
            end
        end
        i_req_valid = '0;
        repeat (5) @(negedge clk);
        i_res_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_size;
        do_reset();
        for (int i = 0; i < 34; i++) begin
            run_one(0, 32'(200 + i), 32'd100, t_rdy, t_mv, t_addr, t_size, t_recip, t_lat, t_price, t_vol, t_full, t_sid);
            exp_size = (i < 32) ? 32'(i + 1) : 32'd32;
            n_cmp++; if (t_addr !== 7'(i % 32) || t_size !== exp_size || t_lat !== 3) begin
                n_bad++; $display("FAIL wrap_txn%0d: got addr %0d size %0d lat %0d want addr %0d size %0d lat 3",
                                  i, t_addr, t_size, t_lat, i % 32, exp_size);
            end
            n_cmp++; if (t_recip !== (64'h1_0000_0000 / 64'(exp_size))) begin
                n_bad++; $display("FAIL wrap_recip%0d: got %h want %h", i, t_recip, 64'h1_0000_0000 / 64'(exp_size));
            end
            n_cmp++; if (t_full !== (i >= 31) || t_price !== 32'((300 + i) / 2)) begin
                n_bad++; $display("FAIL wrap_result%0d: got full %b price %0d want full %b price %0d",
                                  i, t_full, t_price, (i >= 31), (300 + i) / 2);
            end
        end
        n_cmp++; if (t_recip !== 64'h0800_0000) begin n_bad++; $display("FAIL wrap_recip_sat: got %h want 08000000", t_recip); end
        for (int i = 0; i < 33; i++) begin
            run_one(2, 32'd50, 32'd40, t_rdy, t_mv, t_addr, t_size, t_recip, t_lat, t_price, t_vol, t_full, t_sid);
        end
        n_cmp++; if (t_addr !== 7'd64 || t_size !== 32'd32) begin
            n_bad++; $display("FAIL wrap_stock2_33rd: got addr %0d size %0d want addr 64 size 32", t_addr, t_size);
        end
    endtask

    task automatic test_reset_mid();
        i_req_valid = 4'b0100;
        i_req_ask[2*DW +: DW] = 32'd10;
        i_req_bid[2*DW +: DW] = 32'd20;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (dut.state_q !== volatility_pkg::SETTLE) begin n_bad++; $display("FAIL midrst_in_settle: got %0d want %0d", dut.state_q, volatility_pkg::SETTLE); end
        i_reset_n = 1'b0;
        i_req_valid = '0;
        @(negedge clk);
        n_cmp++; if (all_outs !== '0 || o_req_ready !== 4'b0) begin n_bad++; $display("FAIL midrst_outputs: got %h want 0", all_outs); end
        i_reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_res_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_result_lost: got %b want 0", o_res_valid); end
        run_one(2, 32'd10, 32'd20, t_rdy, t_mv, t_addr, t_size, t_recip, t_lat, t_price, t_vol, t_full, t_sid);
        n_cmp++; if (t_addr !== 7'd64 || t_size !== 32'd1 || t_lat !== 3) begin
            n_bad++; $display("FAIL midrst_next_write: got addr %0d size %0d lat %0d want addr 64 size 1 lat 3", t_addr, t_size, t_lat);
        end
    endtask

    task automatic test_sticky();
        n_cmp++; if (dut.sticky_err_q !== 1'b0) begin n_bad++; $display("FAIL sticky_clear: got %b want 0", dut.sticky_err_q); end
        mem_dv = 1'b0;
        run_one(1, 32'd30, 32'd10, t_rdy, t_mv, t_addr, t_size, t_recip, t_lat, t_price, t_vol, t_full, t_sid);
        mem_dv = 1'b1;
        n_cmp++; if (t_lat !== 3 || t_price !== 32'd20) begin n_bad++; $display("FAIL sticky_capture: got lat %0d price %0d want lat 3 price 20", t_lat, t_price); end
        n_cmp++; if (dut.sticky_err_q !== 1'b1) begin n_bad++; $display("FAIL sticky_set: got %b want 1", dut.sticky_err_q); end
    endtask

    task automatic test_backpressure();
        logic [63:0] vol0;
        logic [31:0] price0;
        logic [1:0]  sid0;
        logic        full0;
        int          lat;
        int          transfers;
        i_res_ready = 1'b0;
        i_req_valid = 4'b1000;
        i_req_ask[3*DW +: DW] = 32'd60;
        i_req_bid[3*DW +: DW] = 32'd40;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 4'hF;
        lat = 1;
        while (!o_res_valid && lat < 10) begin @(negedge clk); lat++; end
        vol0 = o_res_volatility; price0 = o_res_price; sid0 = o_res_stock_id; full0 = o_res_full;
        n_cmp++; if (price0 !== 32'd50 || sid0 !== 2'd3 || lat !== 3) begin
            n_bad++; $display("FAIL bp_first: got price %0d stock %0d lat %0d want 50 3 3", price0, sid0, lat);
        end
        for (int c = 0; c < 10; c++) begin
            vol_noise = 64'(c + 1);
            @(negedge clk);
            n_cmp++; if (o_res_valid !== 1'b1 || o_res_volatility !== vol0 || o_res_price !== price0 ||
                         o_res_stock_id !== sid0 || o_res_full !== full0 || o_req_ready !== 4'b0) begin
                n_bad++; $display("FAIL bp_hold%0d: got valid %b vol %h price %0d ready %b want 1 %h %0d 0000",
                                  c, o_res_valid, o_res_volatility, o_res_price, o_req_ready, vol0, price0);
            end
        end
        vol_noise = '0;
        i_req_valid = '0;
        i_res_ready = 1'b1;
        transfers = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (o_res_valid && i_res_ready) transfers++;
            @(negedge clk);
        end
        i_res_ready = 1'b0;
        $display("backpressure transfers=%0d", transfers);
        n_cmp++; if (transfers != 1) begin n_bad++; $display("FAIL bp_transfers: got %0d want 1", transfers); end
    endtask

    task automatic test_skip_zero();
        do_reset();
`ifdef SKIP_ZERO_QUOTE_EN
        int mv_seen;
        i_req_valid = 4'b1000;
        i_req_ask[3*DW +: DW] = 32'd0;
        i_req_bid[3*DW +: DW] = 32'd50;
        #1;
        n_cmp++; if (o_req_ready !== 4'b1000) begin n_bad++; $display("FAIL skip_ready: got %b want 1000", o_req_ready); end
        @(posedge clk);
        @(negedge clk);
        i_req_valid = '0;
        mv_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_mem_valid) mv_seen++;
            @(negedge clk);
        end
        n_cmp++; if (mv_seen != 0) begin n_bad++; $display("FAIL skip_no_issue: got %0d strobes want 0", mv_seen); end
        run_one(3, 32'd70, 32'd50, t_rdy, t_mv, t_addr, t_size, t_recip, t_lat, t_price, t_vol, t_full, t_sid);
        n_cmp++; if (t_addr !== 7'd96 || t_size !== 32'd1 || t_mv !== 1'b1) begin
            n_bad++; $display("FAIL skip_next_write: got addr %0d size %0d mv %b want 96 1 1", t_addr, t_size, t_mv);
        end
`else
        run_one(3, 32'd0, 32'd50, t_rdy, t_mv, t_addr, t_size, t_recip, t_lat, t_price, t_vol, t_full, t_sid);
        n_cmp++; if (t_mv !== 1'b1 || t_addr !== 7'd96 || t_price !== 32'd25) begin
            n_bad++; $display("FAIL zero_quote_issue: got mv %b addr %0d price %0d want 1 96 25", t_mv, t_addr, t_price);
        end
        run_one(3, 32'd70, 32'd50, t_rdy, t_mv, t_addr, t_size, t_recip, t_lat, t_price, t_vol, t_full, t_sid);
        n_cmp++; if (t_addr !== 7'd97 || t_size !== 32'd2) begin
            n_bad++; $display("FAIL zero_quote_next: got addr %0d size %0d want 97 2", t_addr, t_size);
        end
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n   = 1'b0;
        i_req_valid = '0;
        i_res_ready = 1'b0;
        mem_dv      = 1'b1;
        vol_noise   = '0;
        for (int s = 0; s < NS; s++) begin
            i_req_ask[s*DW +: DW] = 32'd100;
            i_req_bid[s*DW +: DW] = 32'd90;
        end
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_sticky();
        test_backpressure();
        test_skip_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
